// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop consume both operands LSB-first.
// start/busy/done handshake; the result is held from done until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             dbg_state
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] work_d;

    // Full-adder slice on the current LSBs; new sum bits enter at the MSB.
    assign s_d    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    assign work_d = {s_d, work_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    c_q    <= c_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    // On the MSB step c_q is still the carry into the MSB.
                    if (cnt_q == LAST) begin
                        sum_q   <= work_d;
                        cout_q  <= c_d;
                        ovf_q   <= c_q ^ c_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): scoreboard of {ovf,cout,sum} checked on done.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         dbg_state;

    logic [W+1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_seen = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                check("result", 64'({ovf, cout, sum}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(model(x, y, c));
    endtask

    // One isolated operation: measures start-to-done latency and busy cycles.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        drive(x, y, c);
        @(negedge clk);
        start    = 1'b0;
        a        = ~x;
        b        = ~y;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check("done_seen_in_budget", 64'(done), 64'(1));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 40);
    endtask

    initial begin
        int lat, bc, cyc, d0;
        logic [W-1:0] x, y;
        logic         c;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_res", 64'({ovf, cout, sum}), 64'(0));
        rst_n = 1'b1;

        // Basic latency and busy width
        do_op(8'h3C, 8'h05, 1'b0, lat, bc);
        check("t1_latency", 64'(lat), 64'(W));
        check("t1_busy_cycles", 64'(bc), 64'(W));
        @(negedge clk);
        check("t1_done_single", 64'(done), 64'(0));

        do_op(8'hFF, 8'h01, 1'b0, lat, bc);
        do_op(8'h7F, 8'h01, 1'b0, lat, bc);
        do_op(8'hFF, 8'hFF, 1'b1, lat, bc);
        do_op(8'h80, 8'h80, 1'b0, lat, bc);

        // start while busy is ignored; result holds during RUN
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b0);
        d0 = done_seen;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        check("t4_sum_hold", 64'({ovf, cout, sum}), 64'(model(8'h80, 8'h80, 1'b0)));
        check("t4_busy", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("t4_done_at", 64'(cyc), 64'(W - 3));
        repeat (15) @(negedge clk);
        check("t4_one_done", 64'(done_seen - d0), 64'(1));

        // Reset mid-operation
        @(negedge clk);
        drive(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        d0 = done_seen;
        @(negedge clk);
        exp_q.delete();
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_done", 64'(done), 64'(0));
        check("t5_res", 64'({ovf, cout, sum}), 64'(0));
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_done", 64'(done_seen - d0), 64'(0));
        do_op(8'h01, 8'h02, 1'b0, lat, bc);
        check("t5_latency", 64'(lat), 64'(W));

        // Back-to-back with start held high: corners first, then random
        @(negedge clk);
        drive(8'h00, 8'h00, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            wait_done(cyc);
            check("t6_period", 64'(cyc), 64'(W + 1));
            if (!done) break;
            if (i < 256) begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
                c = 1'($urandom_range(0, 1));
                if (i <= 8) begin
                    x[W-1] = 1'(((i - 1) >> 2) & 1);
                    y[W-1] = 1'(((i - 1) >> 1) & 1);
                    c      = 1'((i - 1) & 1);
                end
                drive(x, y, c);
            end else begin
                start = 1'b0;
            end
        end
        repeat (12) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
